// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Everything about an accepted request except its word index and store data.
  typedef struct packed {
    logic       wr;
    logic       err;
    logic       sext;
    logic [1:0] size;
    logic [1:0] lane;
  } req_t;

  // Rejection rules: conflicting read/write, illegal size, misaligned half/word.
  function automatic logic req_err(input logic rd, input logic wr,
                                   input logic [1:0] sz, input logic [1:0] lane);
    return (rd & wr) | (sz == 2'b11) |
           ((sz == SZ_HALF) & lane[0]) |
           ((sz == SZ_WORD) & (lane != 2'b00));
  endfunction

  // Byte-lane write enables for a store of the given size at the given lane.
  function automatic logic [NUM_LANES-1:0] lane_en(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: lane_en = 4'b0001 << lane;
      SZ_HALF: lane_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // Replicate the low byte/half of store data across the word so any lane can pick it up.
  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: store_rep = {4{wd[7:0]}};
      SZ_HALF: store_rep = {2{wd[15:0]}};
      default: store_rep = wd;
    endcase
  endfunction

  // Little-endian lane select plus sign/zero extension of a loaded word.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic sext);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: load_ext = {{24{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: load_ext = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM, one storage column per byte lane, synchronous read, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                              clk,
  input  logic [NUM_LANES-1:0]              we,
  input  logic [ADDR_BITS-1:0]              waddr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
  input  logic                              re,
  input  logic [ADDR_BITS-1:0]              raddr,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // Lane write and registered read; read output holds when re is low.
    always_ff @(posedge clk) begin
      if (we[l]) mem[waddr] <= wdata[l];
      if (re)    rd_q       <= mem[raddr];
    end

    assign rdata[l] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one access at a time, fixed wait states,
// pipeline freeze via stop, load lane steering and extension.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        signext_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stop,
  output logic        done,
  output logic        err
);

  // Countdown start; with no wait states the counter is never consulted.
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  req_t                   req_q, live_req, cur_req;
  logic [ADDR_BITS-1:0]   idx_q, cur_idx;
  logic [31:0]            wdata_q;
  logic                   req, accept, enter_done, rd_en;
  logic [NUM_LANES-1:0]   we;
  logic [31:0]            ram_q;

  // Last completed load's steering controls; rdata is derived from these and the
  // RAM output register only, so it holds steady across later stores.
  logic                   ld_zero;
  logic [1:0]             ld_size, ld_lane;
  logic                   ld_sext;

  // Upper address bits are ignored so accesses wrap over the RAM depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_BITS+2];

  assign req    = memread | memwrite;
  assign accept = reset && (state_q == ST_IDLE) && req;

  // Decode the live request; the same record is latched on acceptance.
  always_comb begin
    live_req      = '0;
    live_req.wr   = memwrite;
    live_req.err  = req_err(memread, memwrite, size, addr[1:0]);
    live_req.sext = signext_ld;
    live_req.size = size;
    live_req.lane = addr[1:0];
  end

  // In IDLE the request is still on the inputs; afterwards use the latched copy.
  assign cur_req = (state_q == ST_IDLE) ? live_req : req_q;
  assign cur_idx = (state_q == ST_IDLE) ? addr[ADDR_BITS+1:2] : idx_q;

  // Next state and the stop/done/err outputs.
  always_comb begin
    state_d = state_q;
    stop    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    if (!reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (req) begin
          stop    = 1'b0;
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
        end
        ST_WAIT: begin
          stop = 1'b0;
          if (cnt_q == 4'd0) state_d = ST_DONE;
        end
        ST_DONE: begin
          done    = 1'b1;
          err     = req_q.err;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= CNT_INIT;
      else if (state_q == ST_WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request latch; a discarded request is harmless since the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q   <= live_req;
      idx_q   <= addr[ADDR_BITS+1:2];
      wdata_q <= wdata;
    end
  end

  // Loads read the RAM on the edge that enters DONE, so data is valid with done.
  assign enter_done = reset && (state_d == ST_DONE);
  assign rd_en      = enter_done && !cur_req.wr && !cur_req.err;

  // Stores commit on the edge leaving DONE; a reset in DONE drops the store.
  assign we = {NUM_LANES{(state_q == ST_DONE) && reset && req_q.wr && !req_q.err}}
              & lane_en(req_q.size, req_q.lane);

  dmem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (store_rep(req_q.size, wdata_q)),
    .re    (rd_en),
    .raddr (cur_idx),
    .rdata (ram_q)
  );

  // Capture load steering at DONE entry; errors force zero, clean stores leave it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_zero <= 1'b1;
      ld_size <= SZ_WORD;
      ld_lane <= 2'b00;
      ld_sext <= 1'b0;
    end else if (enter_done && (cur_req.err || !cur_req.wr)) begin
      ld_zero <= cur_req.err;
      ld_size <= cur_req.size;
      ld_lane <= cur_req.lane;
      ld_sext <= cur_req.sext;
    end
  end

  assign rdata = ld_zero ? 32'd0 : load_ext(ram_q, ld_size, ld_lane, ld_sext);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has no wait states, instance 1 has two.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_s    [2];
  logic        memread_s  [2];
  logic        memwrite_s [2];
  logic [1:0]  size_s     [2];
  logic        signext_s  [2];
  logic [31:0] addr_s     [2];
  logic [31:0] wdata_s    [2];
  logic [31:0] rdata_s    [2];
  logic        stop_s     [2];
  logic        done_s     [2];
  logic        err_s      [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  mref [2][4096];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(10)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .memread(memread_s[0]), .memwrite(memwrite_s[0]),
    .size(size_s[0]), .signext_ld(signext_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .rdata(rdata_s[0]), .stop(stop_s[0]), .done(done_s[0]), .err(err_s[0]));

  dmem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(10)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .memread(memread_s[1]), .memwrite(memwrite_s[1]),
    .size(size_s[1]), .signext_ld(signext_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .rdata(rdata_s[1]), .stop(stop_s[1]), .done(done_s[1]), .err(err_s[1]));

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] a;
    logic [31:0] wd;
    bit          e;
    logic [31:0] r;
  } vec_t;

  function automatic int waits(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request in the next cycle and follow it until done (bounded).
  task automatic access(input int d, input bit rd, input bit wr, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a, input logic [31:0] wd,
                        output int stop_lo, output bit got_done, output bit got_err,
                        output logic [31:0] got_rd, output int done_cyc);
    @(negedge clk);
    memread_s[d] = rd; memwrite_s[d] = wr; size_s[d] = sz;
    signext_s[d] = sx; addr_s[d] = a; wdata_s[d] = wd;
    stop_lo = 0; got_done = 0; got_err = 0; got_rd = '0; done_cyc = -1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      #2;
      if (!stop_s[d]) stop_lo++;
      if (err_s[d] && !done_s[d]) check("err_without_done", 32'(err_s[d]), 32'd0);
      if (done_s[d]) begin
        got_done = 1; got_err = err_s[d]; got_rd = rdata_s[d]; done_cyc = cyc;
        memread_s[d] = 0; memwrite_s[d] = 0;
      end else begin
        @(negedge clk);
      end
    end
    memread_s[d] = 0; memwrite_s[d] = 0;
  endtask

  task automatic do_chk(input int d, input string nm, input bit rd, input bit wr,
                        input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd,
                        output int done_cyc);
    int sl; bit gd, ge; logic [31:0] gr;
    access(d, rd, wr, sz, sx, a, wd, sl, gd, ge, gr, done_cyc);
    check({nm, ".done"},  32'(gd), 32'd1);
    check({nm, ".stop0"}, 32'(sl), 32'(waits(d) + 1));
    check({nm, ".err"},   32'(ge), 32'(exp_err));
    check({nm, ".rdata"}, gr, exp_rd);
  endtask

  // Reference load: assemble little-endian bytes, then extend arithmetically.
  function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sx);
    int base = int'(a[11:0]);
    int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mref[d][base + i]) << (8 * i);
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
    int base = int'(a[11:0]);
    int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    logic [31:0] w = wd;
    for (int i = 0; i < n; i++) mref[d][base + i] = w[8*i +: 8];
  endtask

  vec_t tbl [16];

  initial begin
    int dc, dc1, dc2;
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 0; memread_s[d] = 0; memwrite_s[d] = 0; size_s[d] = 2'b10;
      signext_s[d] = 0; addr_s[d] = '0; wdata_s[d] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst.stop",  32'(stop_s[d]), 32'd1);
      check("rst.done",  32'(done_s[d]), 32'd0);
      check("rst.err",   32'(err_s[d]),  32'd0);
      check("rst.rdata", rdata_s[d],     32'd0);
    end
    reset_s[0] = 1; reset_s[1] = 1;

    // Directed sequence on the two-wait-state instance.
    tbl[0]  = '{0, 1, 2'b10, 0, 32'h40, 32'h12345678, 0, 32'h00000000};
    tbl[1]  = '{1, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h12345678};
    tbl[2]  = '{0, 1, 2'b00, 0, 32'h41, 32'h000000A5, 0, 32'h12345678};
    tbl[3]  = '{1, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h1234A578};
    tbl[4]  = '{1, 0, 2'b00, 1, 32'h41, 32'h0,        0, 32'hFFFFFFA5};
    tbl[5]  = '{1, 0, 2'b00, 0, 32'h41, 32'h0,        0, 32'h000000A5};
    tbl[6]  = '{0, 1, 2'b01, 0, 32'h42, 32'h00008001, 0, 32'h000000A5};
    tbl[7]  = '{1, 0, 2'b01, 1, 32'h42, 32'h0,        0, 32'hFFFF8001};
    tbl[8]  = '{1, 0, 2'b01, 0, 32'h42, 32'h0,        0, 32'h00008001};
    tbl[9]  = '{1, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h8001A578};
    tbl[10] = '{1, 0, 2'b10, 0, 32'h42, 32'h0,        1, 32'h00000000};
    tbl[11] = '{0, 1, 2'b01, 0, 32'h43, 32'h00001111, 1, 32'h00000000};
    tbl[12] = '{1, 1, 2'b10, 0, 32'h40, 32'hFFFFFFFF, 1, 32'h00000000};
    tbl[13] = '{1, 0, 2'b11, 0, 32'h40, 32'h0,        1, 32'h00000000};
    tbl[14] = '{0, 1, 2'b10, 0, 32'h42, 32'h0,        1, 32'h00000000};
    tbl[15] = '{1, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h8001A578};
    for (int i = 0; i < 16; i++)
      do_chk(1, $sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx,
             tbl[i].a, tbl[i].wd, tbl[i].e, tbl[i].r, dc);

    // Reset during the wait states of a store: store is dropped.
    @(negedge clk);
    memwrite_s[1] = 1; size_s[1] = 2'b10; addr_s[1] = 32'h40; wdata_s[1] = 32'hDEADBEEF;
    #2 check("rstw.stop_accept", 32'(stop_s[1]), 32'd0);
    @(negedge clk);
    #2 check("rstw.stop_wait", 32'(stop_s[1]), 32'd0);
    reset_s[1] = 0;
    #1 check("rstw.stop_comb", 32'(stop_s[1]), 32'd1);
    memwrite_s[1] = 0;
    @(negedge clk);
    #2;
    check("rstw.stop",  32'(stop_s[1]), 32'd1);
    check("rstw.done",  32'(done_s[1]), 32'd0);
    check("rstw.rdata", rdata_s[1],     32'd0);
    reset_s[1] = 1;
    do_chk(1, "rstw.lw", 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h8001A578, dc);
    last_rd[1] = 32'h8001A578;

    // No wait states: back-to-back done spacing and address aliasing.
    do_chk(0, "z.sw", 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 0, 32'h0, dc1);
    do_chk(0, "z.lw", 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h11223344, dc2);
    check("z.done_gap", 32'(dc2 - dc1), 32'd2);
    do_chk(0, "z.sw_alias", 0, 1, 2'b10, 0, 32'h40 + 32'd4096, 32'hCAFEF00D, 0, 32'h11223344, dc);
    do_chk(0, "z.lw_alias", 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'hCAFEF00D, dc);
    do_chk(0, "z.lw_hi", 1, 0, 2'b10, 0, 32'hFFFFF040, 32'h0, 0, 32'hCAFEF00D, dc);
    last_rd[0] = 32'hCAFEF00D;

    // Randomized traffic over a small window, checked against the byte model.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 8; w++) begin
        logic [31:0] a = 32'h200 + 32'(4 * w);
        logic [31:0] wd = $urandom;
        model_store(d, a, 2'b10, wd);
        do_chk(d, "rinit", 0, 1, 2'b10, 0, a, wd, 0, last_rd[d], dc);
      end
      for (int n = 0; n < 120; n++) begin
        int op = $urandom_range(0, 9);
        bit rd = (op < 5) || (op == 9);
        bit wr = (op >= 5);
        logic [1:0] sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        bit sx = 1'($urandom_range(0, 1));
        logic [31:0] a = ($urandom & 32'hFFFFF000) | 32'h200 | 32'($urandom_range(0, 31));
        logic [31:0] wd = $urandom;
        bit e = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
                (sz == 2'b10 && a % 4 != 0);
        logic [31:0] exp;
        if (e)        exp = 32'h0;
        else if (rd)  exp = model_load(d, a, sz, sx);
        else          exp = last_rd[d];
        if (!e && wr) model_store(d, a, sz, wd);
        last_rd[d] = exp;
        do_chk(d, $sformatf("rnd%0d_%0d", d, n), rd, wr, sz, sx, a, wd, e, exp, dc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
